// File: rtl/life_pkg.sv
// Shared types, preset codes and the B3/S23 cell rule for the Game-of-Life engine.
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_COMMIT
    } life_state_t;

    localparam logic [3:0] PRESET_CLEAR   = 4'd0;
    localparam logic [3:0] PRESET_BLINKER = 4'd1;
    localparam logic [3:0] PRESET_GLIDER  = 4'd2;
    localparam logic [3:0] PRESET_BLOCK   = 4'd3;

    // Birth on exactly three neighbours, survival on two or three.
    function automatic logic life_rule(input logic [3:0] count, input logic alive);
        return (count == 4'd3) || (alive && (count == 4'd2));
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-state of one grid row from the row and its two vertical neighbours.
// LIFE_WRAP_EN: wrap columns around (toroidal); otherwise off-grid columns are dead.
module life_row_next
#(
    parameter int COLS = 16
)
(
    input  logic [COLS-1:0] row_above,
    input  logic [COLS-1:0] row_mid,
    input  logic [COLS-1:0] row_below,
    output logic [COLS-1:0] row_next
);
    import life_pkg::*;

    // One extra column on each side so every cell sees a uniform 3x3 window.
    logic [COLS+1:0] pad_above;
    logic [COLS+1:0] pad_mid;
    logic [COLS+1:0] pad_below;
    logic [3:0]      count;

`ifdef LIFE_WRAP_EN
    assign pad_above = {row_above[0], row_above, row_above[COLS-1]};
    assign pad_mid   = {row_mid[0],   row_mid,   row_mid[COLS-1]};
    assign pad_below = {row_below[0], row_below, row_below[COLS-1]};
`else
    assign pad_above = {1'b0, row_above, 1'b0};
    assign pad_mid   = {1'b0, row_mid,   1'b0};
    assign pad_below = {1'b0, row_below, 1'b0};
`endif

    always_comb begin
        row_next = '0;
        count    = '0;
        for (int c = 0; c < COLS; c++) begin
            count = 4'(pad_above[c]) + 4'(pad_above[c+1]) + 4'(pad_above[c+2])
                  + 4'(pad_mid[c])                       + 4'(pad_mid[c+2])
                  + 4'(pad_below[c]) + 4'(pad_below[c+1]) + 4'(pad_below[c+2]);
            row_next[c] = life_rule(count, row_mid[c]);
        end
    end

endmodule

// File: rtl/life_grid_engine.sv
// Game-of-Life generation engine: two grid banks, row-per-cycle compute, tick timer, read port.
// LIFE_WRAP_EN: toroidal grid (rows and columns wrap); otherwise off-grid neighbours are dead.
module life_grid_engine
    import life_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int TICK_MAX = 100000000,
    parameter int GEN_W    = 16
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enb,
    input  logic                    step,
    input  logic                    load,
    input  logic [3:0]              preset_sel,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    input  logic [$clog2(COLS)-1:0] rd_col,
    output logic                    rd_alive,
    output logic                    busy,
    output logic                    gen_done,
    output logic [GEN_W-1:0]        gen_count,
    output logic                    tick
);

    localparam int ROW_W   = $clog2(ROWS);
    localparam int COL_W   = $clog2(COLS);
    localparam int TIMER_W = $clog2(TICK_MAX);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TICK_MAX - 1);

    logic [COLS-1:0]    cur [ROWS];
    logic [COLS-1:0]    nxt [ROWS];
    logic [COLS-1:0]    preset_grid [ROWS];
    life_state_t        state;
    life_state_t        state_next;
    logic [ROW_W-1:0]   row_idx;
    logic [TIMER_W-1:0] timer;
    logic               load_pend;
    logic [3:0]         preset_reg;
    logic [COLS-1:0]    row_above;
    logic [COLS-1:0]    row_mid;
    logic [COLS-1:0]    row_below;
    logic [COLS-1:0]    row_new;
    logic               trigger;
    logic               start_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign tick       = (timer == TIMER_LAST);
    assign trigger    = (tick && enb) || step;
    assign start_load = load || load_pend;
    assign busy       = (state == ST_COMPUTE) || (state == ST_COMMIT);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_load) begin
                    state_next = ST_LOAD;
                end else if (trigger) begin
                    state_next = ST_COMPUTE;
                end
            end
            ST_LOAD:    state_next = ST_IDLE;
            ST_COMPUTE: if (row_idx == ROW_LAST) state_next = ST_COMMIT;
            ST_COMMIT:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Vertical neighbours of the row being computed; edge rows see dead or wrapped rows.
    always_comb begin
        row_above = '0;
        row_below = '0;
        row_mid   = cur[row_idx];
        if (row_idx != '0) begin
            row_above = cur[row_idx - 1'b1];
        end else begin
`ifdef LIFE_WRAP_EN
            row_above = cur[ROWS-1];
`endif
        end
        if (row_idx != ROW_LAST) begin
            row_below = cur[row_idx + 1'b1];
        end else begin
`ifdef LIFE_WRAP_EN
            row_below = cur[0];
`endif
        end
    end

    life_row_next #(.COLS(COLS)) u_row_next (
        .row_above (row_above),
        .row_mid   (row_mid),
        .row_below (row_below),
        .row_next  (row_new)
    );

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            preset_grid[r] = '0;
        end
        case (preset_reg)
            PRESET_BLINKER: preset_grid[1][2:0] = 3'b111;
            PRESET_GLIDER: begin
                preset_grid[0][1]   = 1'b1;
                preset_grid[1][2]   = 1'b1;
                preset_grid[2][2:0] = 3'b111;
            end
            PRESET_BLOCK: begin
                preset_grid[0][1:0] = 2'b11;
                preset_grid[1][1:0] = 2'b11;
            end
            default: ;
        endcase
    end

    // A load that arrives outside IDLE is remembered and replayed once the engine returns there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            row_idx    <= '0;
            load_pend  <= 1'b0;
            preset_reg <= '0;
            gen_count  <= '0;
            gen_done   <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                cur[r] <= '0;
                nxt[r] <= '0;
            end
        end else begin
            state    <= state_next;
            gen_done <= (state == ST_COMMIT);
            if (load) begin
                preset_reg <= preset_sel;
            end
            if (load && (state != ST_IDLE)) begin
                load_pend <= 1'b1;
            end else if ((state == ST_IDLE) && start_load) begin
                load_pend <= 1'b0;
            end
            case (state)
                ST_IDLE: row_idx <= '0;
                ST_LOAD: begin
                    gen_count <= '0;
                    for (int r = 0; r < ROWS; r++) begin
                        cur[r] <= preset_grid[r];
                        nxt[r] <= '0;
                    end
                end
                ST_COMPUTE: begin
                    nxt[row_idx] <= row_new;
                    row_idx      <= row_idx + 1'b1;
                end
                ST_COMMIT: begin
                    gen_count <= gen_count + 1'b1;
                    for (int r = 0; r < ROWS; r++) begin
                        cur[r] <= nxt[r];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_alive <= 1'b0;
        end else if (({1'b0, rd_row} < (ROW_W+1)'(ROWS)) && ({1'b0, rd_col} < (COL_W+1)'(COLS))) begin
            rd_alive <= cur[rd_row][rd_col];
        end else begin
            rd_alive <= 1'b0;
        end
    end

endmodule

// File: tb/tb_life_grid_engine.sv
// Self-checking bench for life_grid_engine on an 8x8 grid; expectations follow LIFE_WRAP_EN when defined.
module tb_life_grid_engine;

    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int TICK_MAX = 4;
    localparam int GEN_W    = 8;

    localparam logic [63:0] GRID_BLINKER  = 64'h0000_0000_0000_0700;
    localparam logic [63:0] GRID_VERTICAL = 64'h0000_0000_0002_0202;
    localparam logic [63:0] GRID_GLIDER   = 64'h0000_0000_0007_0402;
    localparam logic [63:0] GRID_BLOCK    = 64'h0000_0000_0000_0303;

    typedef struct {
        logic [GEN_W-1:0] gen;
        int               issue;
    } sb_entry_t;

    logic             clk;
    logic             reset;
    logic             enb;
    logic             step;
    logic             load;
    logic [3:0]       preset_sel;
    logic [2:0]       rd_row;
    logic [2:0]       rd_col;
    logic             rd_alive;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;
    logic             tick;

    int               checks;
    int               failures;
    int               cyc;
    sb_entry_t        sb [$];
    sb_entry_t        popped;
    logic [63:0]      model;
    logic [GEN_W-1:0] exp_gen;
    logic [63:0]      grid;

    life_grid_engine #(
        .ROWS(ROWS), .COLS(COLS), .TICK_MAX(TICK_MAX), .GEN_W(GEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .step       (step),
        .load       (load),
        .preset_sel (preset_sel),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_alive   (rd_alive),
        .busy       (busy),
        .gen_done   (gen_done),
        .gen_count  (gen_count),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Independent reference: plain neighbour count over the bench grid image (bit r*8+c).
    function automatic logic [63:0] next_gen(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        int rr;
        int cc;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef LIFE_WRAP_EN
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
`endif
                            if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                                cnt += int'(g[rr*COLS+cc]);
                            end
                        end
                    end
                end
                n[r*COLS+c] = (cnt == 3) || (g[r*COLS+c] && cnt == 2);
            end
        end
        return n;
    endfunction

    function automatic logic [63:0] preset_image(input logic [3:0] sel);
        case (sel)
            4'd1:    return GRID_BLINKER;
            4'd2:    return GRID_GLIDER;
            4'd3:    return GRID_BLOCK;
            default: return 64'h0;
        endcase
    endfunction

    // Scoreboard consumer: every gen_done must match a pending trigger, in order and on time.
    always @(negedge clk) begin
        if (reset && gen_done) begin
            checkOutput("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                popped = sb.pop_front();
                checkOutput("gen_count_at_done", 64'(gen_count), 64'(popped.gen));
                checkOutput("done_latency", 64'(cyc - popped.issue), 64'(ROWS + 1));
            end
        end
    end

    task automatic readGrid(output logic [63:0] g);
        g = '0;
        for (int i = 0; i <= ROWS*COLS; i++) begin
            @(negedge clk);
            if (i > 0) g[i-1] = rd_alive;
            if (i < ROWS*COLS) begin
                rd_row = 3'(i / COLS);
                rd_col = 3'(i % COLS);
            end
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 4*ROWS + 8 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic doLoad(input logic [3:0] sel, input logic with_step);
        @(negedge clk);
        load = 1'b1;
        preset_sel = sel;
        step = with_step;
        @(negedge clk);
        load = 1'b0;
        step = 1'b0;
        repeat (2) @(negedge clk);
        model   = preset_image(sel);
        exp_gen = '0;
    endtask

    task automatic applyStimulus();
        model   = next_gen(model);
        exp_gen = exp_gen + 1'b1;
        @(negedge clk);
        step = 1'b1;
        sb.push_back('{gen: exp_gen, issue: cyc + 1});
        @(negedge clk);
        step = 1'b0;
        checkOutput("busy_after_step", 64'(busy), 64'd1);
        waitDrain();
    endtask

    initial begin
        int last_tick;
        checks = 0;
        failures = 0;
        cyc = 0;
        enb = 1'b0;
        step = 1'b0;
        load = 1'b0;
        preset_sel = '0;
        rd_row = '0;
        rd_col = '0;
        model = '0;
        exp_gen = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_gen_done", 64'(gen_done), 64'd0);
        checkOutput("reset_gen_count", 64'(gen_count), 64'd0);
        checkOutput("reset_tick", 64'(tick), 64'd0);
        checkOutput("reset_rd_alive", 64'(rd_alive), 64'd0);
        reset = 1'b1;
        readGrid(grid);
        checkOutput("grid_after_reset", grid, 64'h0);

        $display("[TB] blinker");
        doLoad(4'd1, 1'b0);
        readGrid(grid);
        checkOutput("grid_blinker_loaded", grid, GRID_BLINKER);
        checkOutput("gen_count_after_load", 64'(gen_count), 64'd0);
        applyStimulus();
        readGrid(grid);
        checkOutput("grid_blinker_gen1", grid, GRID_VERTICAL);
        checkOutput("grid_blinker_gen1_model", grid, model);
        applyStimulus();
        readGrid(grid);
        checkOutput("grid_blinker_gen2", grid, GRID_BLINKER);
        checkOutput("gen_count_blinker", 64'(gen_count), 64'd2);

        $display("[TB] block still life");
        doLoad(4'd3, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus();
        readGrid(grid);
        checkOutput("grid_block_5", grid, GRID_BLOCK);
        checkOutput("gen_count_block", 64'(gen_count), 64'd5);

        $display("[TB] glider 32 generations");
        doLoad(4'd2, 1'b0);
        for (int i = 0; i < 32; i++) applyStimulus();
        readGrid(grid);
        checkOutput("grid_glider_32_model", grid, model);
`ifdef LIFE_WRAP_EN
        checkOutput("grid_glider_returns", grid, GRID_GLIDER);
`endif
        checkOutput("gen_count_glider", 64'(gen_count), 64'd32);

        $display("[TB] tick driven run");
        doLoad(4'd1, 1'b0);
        last_tick = -1;
        @(negedge clk);
        enb = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (tick) begin
                if (last_tick >= 0) checkOutput("tick_period", 64'(cyc - last_tick), 64'(TICK_MAX));
                last_tick = cyc;
                if (!busy) begin
                    model   = next_gen(model);
                    exp_gen = exp_gen + 1'b1;
                    sb.push_back('{gen: exp_gen, issue: cyc + 1});
                end
            end
            @(negedge clk);
        end
        enb = 1'b0;
        waitDrain();
        checkOutput("gen_count_ticks", 64'(gen_count), 64'(exp_gen));
        readGrid(grid);
        checkOutput("grid_ticks_model", grid, model);

        $display("[TB] load and step together");
        doLoad(4'd1, 1'b1);
        repeat (ROWS + 6) @(negedge clk);
        checkOutput("gen_count_load_step", 64'(gen_count), 64'd0);
        checkOutput("busy_load_step", 64'(busy), 64'd0);
        readGrid(grid);
        checkOutput("grid_load_step", grid, GRID_BLINKER);

        $display("[TB] load during compute");
        doLoad(4'd3, 1'b0);
        model   = next_gen(model);
        exp_gen = 1;
        @(negedge clk);
        step = 1'b1;
        sb.push_back('{gen: exp_gen, issue: cyc + 1});
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        load = 1'b1;
        preset_sel = 4'd1;
        @(negedge clk);
        load = 1'b0;
        waitDrain();
        repeat (3) @(negedge clk);
        model   = GRID_BLINKER;
        exp_gen = '0;
        checkOutput("gen_count_pending_load", 64'(gen_count), 64'd0);
        readGrid(grid);
        checkOutput("grid_pending_load", grid, model);

        $display("[TB] reset during compute");
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        rd_row = 3'd1;
        rd_col = 3'd1;
        repeat (3) @(negedge clk);
        checkOutput("busy_before_reset", 64'(busy), 64'd1);
        checkOutput("rd_before_reset", 64'(rd_alive), 64'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_busy", 64'(busy), 64'd0);
        checkOutput("async_gen_done", 64'(gen_done), 64'd0);
        checkOutput("async_gen_count", 64'(gen_count), 64'd0);
        checkOutput("async_tick", 64'(tick), 64'd0);
        checkOutput("async_rd_alive", 64'(rd_alive), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        model   = '0;
        exp_gen = '0;
        readGrid(grid);
        checkOutput("grid_after_midreset", grid, 64'h0);
        checkOutput("gen_count_after_midreset", 64'(gen_count), 64'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
